// File: rtl/nvram_autosave.sv
// Shared-port NVRAM manager: loader restore/save of N regions plus periodic checksum autosave.
// Define NVRAM_AUTOSAVE_CRC_EN to checksum with CRC-16/CCITT instead of a 16-bit additive sum.
module nvram_autosave #(
  parameter int DUMPWIDTH = 6,
  parameter int REGIONS   = 2,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2,
  parameter int INTERVAL  = 65536
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  paused,
  input  logic                                  autosave,
  input  logic                                  ioctl_download,
  input  logic                                  ioctl_upload,
  input  logic                                  ioctl_wr,
  input  logic [DUMPWIDTH+$clog2(REGIONS)-1:0]  ioctl_addr,
  input  logic [7:0]                            ioctl_index,
  input  logic [7:0]                            ioctl_dout,
  output logic [7:0]                            ioctl_din,
  output logic                                  ioctl_upload_req,
  output logic                                  pause_cpu,
  output logic [$clog2(REGIONS)-1:0]            nvram_region,
  output logic [DUMPWIDTH-1:0]                  nvram_address,
  input  logic [7:0]                            nvram_data_out,
  output logic [7:0]                            nvram_data_in,
  output logic                                  nvram_write
);

  localparam int RW     = $clog2(REGIONS);
  localparam int AW     = DUMPWIDTH + RW;
  localparam int SW     = AW + 1;
  localparam int NBYTES = REGIONS << DUMPWIDTH;
  localparam int CW     = $clog2(INTERVAL);
  localparam int PW     = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;

  typedef enum logic [2:0] {IDLE, DOWNLOAD, UPLOAD, REQ, PAD, READ, CHECK, SIGNAL} state_t;

`ifdef NVRAM_AUTOSAVE_CRC_EN
  localparam logic [15:0] SUM_INIT = 16'hFFFF;

  function automatic logic [15:0] accumulate(input logic [15:0] acc, input logic [7:0] b);
    logic [15:0] c;
    c = acc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
`else
  localparam logic [15:0] SUM_INIT = 16'h0000;

  function automatic logic [15:0] accumulate(input logic [15:0] acc, input logic [7:0] b);
    return acc + {8'h00, b};
  endfunction
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pad_q, pad_d;
  logic [SW-1:0] idx_q, idx_d;
  logic          rd_vld_q, rd_vld_d;
  logic [15:0]   sum_q, sum_d;
  logic [15:0]   baseline_q, baseline_d;
  logic          baseline_valid_q, baseline_valid_d;
  logic          rebase_q, rebase_d;
  logic          pause_q, pause_d;
  logic          req_q, req_d;
  logic [7:0]    din_q, din_d;
  logic          xfer, xfer_dl, xfer_ul;
  logic [AW-1:0] port_addr;

  assign xfer    = (ioctl_index == 8'(DUMPINDEX));
  assign xfer_dl = ioctl_download && xfer;
  assign xfer_ul = ioctl_upload && xfer;

  // Loader transfers own the core port; otherwise the scan index drives it.
  assign port_addr                     = (xfer_dl || xfer_ul) ? ioctl_addr : idx_q[AW-1:0];
  assign {nvram_region, nvram_address} = port_addr;
  assign nvram_write                   = (state_q == DOWNLOAD) && ioctl_wr;
  assign nvram_data_in                 = (state_q == DOWNLOAD) ? ioctl_dout : 8'h00;
  assign ioctl_din                     = din_q;
  assign ioctl_upload_req              = req_q;
  assign pause_cpu                     = pause_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    pad_d            = pad_q;
    idx_d            = idx_q;
    rd_vld_d         = 1'b0;
    sum_d            = sum_q;
    baseline_d       = baseline_q;
    baseline_valid_d = baseline_valid_q;
    rebase_d         = rebase_q;
    din_d            = din_q;
    case (state_q)
      IDLE: begin
        if (xfer_dl) state_d = DOWNLOAD;
        else if (xfer_ul) state_d = UPLOAD;
        else if (autosave && baseline_valid_q && !ioctl_download && !ioctl_upload) begin
          if (cnt_q == CW'(INTERVAL - 1)) state_d = REQ;
          else cnt_d = cnt_q + CW'(1);
        end
      end
      DOWNLOAD: begin
        if (!ioctl_download) begin
          state_d  = REQ;
          rebase_d = 1'b1;
        end
      end
      UPLOAD: begin
        din_d = nvram_data_out;
        if (!ioctl_upload) begin
          state_d  = REQ;
          rebase_d = 1'b1;
        end
      end
      SIGNAL: begin
        if (xfer_ul) state_d = UPLOAD;
        else if (xfer_dl) state_d = DOWNLOAD;
        else if (!autosave) state_d = IDLE;
      end
      default: begin
        // Scan states: any loader transfer preempts the scan outright.
        if (xfer_dl) state_d = DOWNLOAD;
        else if (xfer_ul) state_d = UPLOAD;
        else begin
          case (state_q)
            REQ: begin
              if (paused) begin
                state_d = PAD;
                pad_d   = '0;
              end
            end
            PAD: begin
              if (!paused) state_d = REQ;
              else if (pad_q == PW'(PAUSEPAD - 1)) begin
                state_d = READ;
                idx_d   = '0;
                sum_d   = SUM_INIT;
              end else pad_d = pad_q + PW'(1);
            end
            READ: begin
              if (!paused) state_d = REQ;
              else begin
                // Core data arrives one cycle after its address.
                if (rd_vld_q) sum_d = accumulate(sum_q, nvram_data_out);
                if (idx_q != SW'(NBYTES)) begin
                  idx_d    = idx_q + SW'(1);
                  rd_vld_d = 1'b1;
                end else state_d = CHECK;
              end
            end
            CHECK: begin
              if (rebase_q || !baseline_valid_q) begin
                baseline_d       = sum_q;
                baseline_valid_d = 1'b1;
                rebase_d         = 1'b0;
                state_d          = IDLE;
              end else if (sum_q != baseline_q) state_d = SIGNAL;
              else state_d = IDLE;
            end
            default: ;
          endcase
        end
      end
    endcase
    pause_d = (state_d == UPLOAD) || (state_d == REQ) || (state_d == PAD) || (state_d == READ);
    req_d   = (state_d == SIGNAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      pad_q            <= '0;
      idx_q            <= '0;
      rd_vld_q         <= 1'b0;
      sum_q            <= 16'h0000;
      baseline_q       <= 16'h0000;
      baseline_valid_q <= 1'b0;
      rebase_q         <= 1'b0;
      pause_q          <= 1'b0;
      req_q            <= 1'b0;
      din_q            <= 8'h00;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pad_q            <= pad_d;
      idx_q            <= idx_d;
      rd_vld_q         <= rd_vld_d;
      sum_q            <= sum_d;
      baseline_q       <= baseline_d;
      baseline_valid_q <= baseline_valid_d;
      rebase_q         <= rebase_d;
      pause_q          <= pause_d;
      req_q            <= req_d;
      din_q            <= din_d;
    end
  end

endmodule

// File: tb/tb_nvram_autosave.sv
// Randomised bench for nvram_autosave: core RAM + pause block models, and a dump-level checksum model
// deciding whether each scan must raise an upload request.
module tb_nvram_autosave;

  localparam int DW       = 6;
  localparam int RW       = 1;
  localparam int AW       = DW + RW;
  localparam int NB       = 1 << AW;
  localparam int INTERVAL = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          paused;
  logic          autosave = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_index = 8'd4;
  logic [7:0]    ioctl_dout = 8'h00;
  logic [7:0]    ioctl_din;
  logic          ioctl_upload_req;
  logic          pause_cpu;
  logic [RW-1:0] nvram_region;
  logic [DW-1:0] nvram_address;
  logic [7:0]    nvram_data_out;
  logic [7:0]    nvram_data_in;
  logic          nvram_write;

  logic [7:0]    ramMem [NB];
  logic [7:0]    ramDout = 8'h00;
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeAddr = '0;
  logic [7:0]    pokeData = 8'h00;
  logic          pz1 = 1'b0;
  logic          pz2 = 1'b0;
  logic          dropPaused = 1'b0;

  logic [7:0]    refMem [NB];
  logic [15:0]   modelBaseline = 16'h0000;
  logic          modelValid = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  int            writesSeen = 0;

  nvram_autosave #(
    .DUMPWIDTH(DW), .REGIONS(2), .DUMPINDEX(4), .PAUSEPAD(2), .INTERVAL(INTERVAL)
  ) dut (
    .clk(clk), .reset(reset), .paused(paused), .autosave(autosave),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_upload_req(ioctl_upload_req), .pause_cpu(pause_cpu),
    .nvram_region(nvram_region), .nvram_address(nvram_address),
    .nvram_data_out(nvram_data_out), .nvram_data_in(nvram_data_in), .nvram_write(nvram_write)
  );

  always #5 clk = ~clk;

  // Core NVRAM: synchronous read, one write port shared by the DUT and CPU-style pokes.
  always @(posedge clk) begin
    if (pokeEn) ramMem[pokeAddr] <= pokeData;
    else if (nvram_write) ramMem[{nvram_region, nvram_address}] <= nvram_data_in;
    ramDout <= ramMem[{nvram_region, nvram_address}];
  end
  assign nvram_data_out = ramDout;

  // Pause block: acknowledges two cycles after the request, can be forced low.
  always @(posedge clk) begin
    pz1 <= pause_cpu;
    pz2 <= pz1;
  end
  assign paused = pz2 && !dropPaused;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelChecksum();
    logic [15:0] acc;
`ifdef NVRAM_AUTOSAVE_CRC_EN
    logic fb;
    acc = 16'hFFFF;
    for (int a = 0; a < NB; a++)
      for (int b = 7; b >= 0; b--) begin
        fb  = acc[15] ^ refMem[a][b];
        acc = {acc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
`else
    acc = 16'h0000;
    for (int a = 0; a < NB; a++) acc = acc + 16'(refMem[a]);
`endif
    return acc;
  endfunction

  function automatic logic expectReq();
    return modelValid && (modelChecksum() != modelBaseline);
  endfunction

  task automatic rebaseModel();
    modelBaseline = modelChecksum();
    modelValid    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dl, input logic ul, input logic wr,
                               input logic [AW-1:0] addr, input logic [7:0] dout);
    ioctl_download = dl;
    ioctl_upload   = ul;
    ioctl_wr       = wr;
    ioctl_addr     = addr;
    ioctl_dout     = dout;
    #1;
    if (nvram_write) writesSeen++;
    tick();
  endtask

  task automatic runCycles(input int n, output int rises, output int reqHigh);
    logic prev;
    rises   = 0;
    reqHigh = 0;
    prev    = pause_cpu;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pause_cpu && !prev) rises++;
      if (ioctl_upload_req) reqHigh++;
      prev = pause_cpu;
    end
  endtask

  // Waits for a complete scan (pause_cpu high then low) plus a few cycles for the verdict.
  task automatic waitScanDone(input string tag);
    int n;
    n = 0;
    while (pause_cpu !== 1'b1 && n < 3000) begin tick(); n++; end
    while (pause_cpu !== 1'b0 && n < 3000) begin tick(); n++; end
    if (n >= 3000) checkOutput({tag, "Timeout"}, 16'd0, 16'd1);
    repeat (3) tick();
  endtask

  task automatic waitReadIndex(input int target, input string tag);
    int n;
    n = 0;
    while (!(pause_cpu && paused && int'({nvram_region, nvram_address}) == target) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) checkOutput({tag, "Timeout"}, 16'd0, 16'd1);
  endtask

  task automatic pokeRam(input int a, input logic [7:0] d);
    pokeAddr = AW'(a);
    pokeData = d;
    pokeEn   = 1'b1;
    tick();
    pokeEn    = 1'b0;
    refMem[a] = d;
  endtask

  task automatic doDownload(input int mode);
    logic [7:0] d;
    int errs;
    ioctl_index = 8'd4;
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'h00);
    writesSeen = 0;
    for (int a = 0; a < NB; a++) begin
      d = (mode == 0) ? 8'(a) : 8'($urandom_range(0, 255));
      if (mode == 1 && a == 0) d = 8'h12;
      if (mode == 1 && a == 1) d = 8'h34;
      applyStimulus(1'b1, 1'b0, 1'b1, AW'(a), d);
      applyStimulus(1'b1, 1'b0, 1'b0, AW'(a), d);
      refMem[a] = d;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 8'h00);
    checkOutput("dlPauseAfterFall", 16'(pause_cpu), 16'd1);
    checkOutput("dlWriteCount", 16'(writesSeen), 16'(NB));
    errs = 0;
    for (int a = 0; a < NB; a++) if (ramMem[a] !== refMem[a]) errs++;
    checkOutput("dlContents", 16'(errs), 16'd0);
    rebaseModel();
    waitScanDone("dlScan");
    checkOutput("dlScanReq", 16'(ioctl_upload_req), 16'(expectReq()));
  endtask

  task automatic doUpload(input int nChecks);
    int a;
    ioctl_index = 8'd4;
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 8'h00);
    checkOutput("reqDropOnUpload", 16'(ioctl_upload_req), 16'd0);
    for (int k = 0; k < nChecks; k++) begin
      a = $urandom_range(0, NB - 1);
      applyStimulus(1'b0, 1'b1, 1'b0, AW'(a), 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, AW'(a), 8'h00);
      checkOutput("uploadDin", 16'(ioctl_din), 16'(refMem[a]));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 8'h00);
    rebaseModel();
    waitScanDone("ulScan");
    checkOutput("ulRescanReq", 16'(ioctl_upload_req), 16'(expectReq()));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rises, reqHigh, a, b, w0;
    logic [7:0] d;

    repeat (2) tick();
    checkOutput("rstPause", 16'(pause_cpu), 16'd0);
    checkOutput("rstReq", 16'(ioctl_upload_req), 16'd0);
    checkOutput("rstWrite", 16'(nvram_write), 16'd0);
    checkOutput("rstDin", 16'(ioctl_din), 16'd0);
    reset = 1'b0;
    autosave = 1'b1;

    runCycles(100, rises, reqHigh);
    checkOutput("noScanBeforeBaseline", 16'(rises), 16'd0);

    doDownload(0);

    // Non-selected index traffic must not reach the core.
    w0 = writesSeen;
    ioctl_index = 8'd1;
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, AW'(5), 8'hAA);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 8'h00);
    ioctl_index = 8'd4;
    checkOutput("nonXferWrites", 16'(writesSeen - w0), 16'd0);
    checkOutput("nonXferRam", 16'(ramMem[5]), 16'(refMem[5]));

    runCycles(800, rises, reqHigh);
    checkOutput("idleScanPulses", 16'(rises >= 4), 16'd1);
    checkOutput("idleScanNoReq", 16'(reqHigh), 16'd0);

    waitScanDone("prePoke");
    pokeRam(64 + 3, refMem[64 + 3] + 8'd1);
    waitScanDone("pokeScan");
    checkOutput("pokeReq", 16'(ioctl_upload_req), 16'(expectReq()));
    runCycles(30, rises, reqHigh);
    checkOutput("pokeReqHeld", 16'(reqHigh), 16'd30);
    doUpload(8);
    runCycles(400, rises, reqHigh);
    checkOutput("postUploadNoReq", 16'(reqHigh), 16'd0);

    waitReadIndex(40, "dropWait");
    dropPaused = 1'b1;
    repeat (2) tick();
    checkOutput("dropPauseHeld", 16'(pause_cpu), 16'd1);
    repeat (2) tick();
    dropPaused = 1'b0;
    waitScanDone("dropScan");
    checkOutput("dropScanReq", 16'(ioctl_upload_req), 16'(expectReq()));

    for (int it = 0; it < 2; it++) begin
      a = $urandom_range(0, NB - 1);
      b = (a + $urandom_range(1, NB - 1)) % NB;
      d = 8'($urandom_range(1, 255));
      waitScanDone("preRand");
      pokeRam(a, refMem[a] + d);
      if (it == 1) pokeRam(b, refMem[b] - d);
      waitScanDone("randScan");
      checkOutput("randReq", 16'(ioctl_upload_req), 16'(expectReq()));
      if (expectReq()) begin
        autosave = 1'b0;
        tick();
        checkOutput("reqDropAutosave", 16'(ioctl_upload_req), 16'd0);
        autosave = 1'b1;
        waitScanDone("reScan");
        checkOutput("reScanReq", 16'(ioctl_upload_req), 16'(expectReq()));
        doUpload(3);
      end
    end

    waitReadIndex(40, "rstWait");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midScanRstPause", 16'(pause_cpu), 16'd0);
    checkOutput("midScanRstReq", 16'(ioctl_upload_req), 16'd0);
    checkOutput("midScanRstWrite", 16'(nvram_write), 16'd0);
    tick();
    reset = 1'b0;
    modelValid = 1'b0;
    runCycles(400, rises, reqHigh);
    checkOutput("noScanAfterRst", 16'(rises), 16'd0);

    doDownload(1);
    runCycles(5, rises, reqHigh);
    waitScanDone("preSwap");
    pokeRam(0, refMem[1]);
    pokeRam(1, 8'h12);
    waitScanDone("swapScan");
    checkOutput("swapReq", 16'(ioctl_upload_req), 16'(expectReq()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
